// File: rtl/uart_irq_aggregator_pkg.sv
// Shared types and constants for the UART interrupt aggregator: the sideband
// struct it consumes, the source index map and the register offsets.
package uart_irq_aggregator_pkg;

  localparam int unsigned TL_DW      = 32;
  localparam int unsigned UartIrqNum = 9;
  localparam logic [3:0]  IrqIdNone  = 4'hF;

  localparam int unsigned OffsState  = 32'h00;
  localparam int unsigned OffsEnable = 32'h04;
  localparam int unsigned OffsTest   = 32'h08;
  localparam int unsigned OffsId     = 32'h0C;
  localparam int unsigned OffsOvfCnt = 32'h10;

  typedef enum logic [3:0] {
    IdxTxWatermark = 4'd0,
    IdxTxEmpty     = 4'd1,
    IdxRxWatermark = 4'd2,
    IdxTxDone      = 4'd3,
    IdxRxOverflow  = 4'd4,
    IdxRxFrameErr  = 4'd5,
    IdxRxBreakErr  = 4'd6,
    IdxRxTimeout   = 4'd7,
    IdxRxParityErr = 4'd8
  } uart_irq_idx_e;

  typedef struct packed {
    logic tx;
    logic tx_en;
    logic rx_idle;
    logic intr_rx_parity_err;
    logic intr_rx_timeout;
    logic intr_rx_break_err;
    logic intr_rx_frame_err;
    logic intr_rx_overflow;
    logic intr_tx_done;
    logic intr_rx_watermark;
    logic intr_tx_empty;
    logic intr_tx_watermark;
  } uart_sideband_o_t;

endpackage

// File: rtl/uart_irq_aggregator_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag; generic so other
// peripheral aggregators can reuse it.
module irq_prio_enc #(
  parameter int unsigned Width = 9,
  parameter int unsigned IdW   = $clog2(Width)
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdW-1:0]   idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest set index is the last assignment.
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdW'(i);
    end
  end

endmodule

// File: rtl/uart_irq_aggregator.sv
// Aggregates the nine UART interrupt lines into sticky, maskable pending bits,
// drives one registered interrupt plus source ID, and exposes a register port.
module uart_irq_aggregator
  import uart_irq_aggregator_pkg::*;
#(
  parameter int unsigned CntW  = 16,
  parameter int unsigned AddrW = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  uart_sideband_o_t     uart_sb_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [AddrW-1:0]     reg_addr_i,
  input  logic [TL_DW-1:0]     reg_wdata_i,
  output logic                 reg_rvalid_o,
  output logic [TL_DW-1:0]     reg_rdata_o,
  output logic                 reg_err_o,
  output logic                 irq_o,
  output logic [3:0]           irq_id_o
);

  localparam int unsigned NumSrc = UartIrqNum;

  logic [NumSrc-1:0] src;
  logic [NumSrc-1:0] rise;
  logic [NumSrc-1:0] prev_p0;
  logic [NumSrc-1:0] pending_p0;
  logic [NumSrc-1:0] enable_p0;
  logic [NumSrc-1:0] active;
  logic [NumSrc-1:0] clr_mask;
  logic [NumSrc-1:0] set_mask;
  logic [CntW-1:0]   ovf_cnt_p0;
  logic              ovf_rise;
  logic              addr_ok;
  logic              wr_state, wr_enable, wr_test, wr_cnt;
  logic [TL_DW-1:0]  rd_data;
  logic              enc_valid;
  logic [3:0]        enc_idx;
  logic              unused_ok;

  assign src = {uart_sb_i.intr_rx_parity_err, uart_sb_i.intr_rx_timeout,
                uart_sb_i.intr_rx_break_err,  uart_sb_i.intr_rx_frame_err,
                uart_sb_i.intr_rx_overflow,   uart_sb_i.intr_tx_done,
                uart_sb_i.intr_rx_watermark,  uart_sb_i.intr_tx_empty,
                uart_sb_i.intr_tx_watermark};

  assign unused_ok = ^{reg_wdata_i[TL_DW-1:NumSrc], uart_sb_i.tx,
                       uart_sb_i.tx_en, uart_sb_i.rx_idle};

  assign rise     = src & ~prev_p0;
  assign ovf_rise = rise[IdxRxOverflow];

  // Misaligned or past-the-end accesses are rejected without side effects.
  assign addr_ok   = (reg_addr_i[1:0] == 2'b00) && (reg_addr_i <= AddrW'(OffsOvfCnt));
  assign wr_state  = reg_req_i && reg_we_i && addr_ok && (reg_addr_i == AddrW'(OffsState));
  assign wr_enable = reg_req_i && reg_we_i && addr_ok && (reg_addr_i == AddrW'(OffsEnable));
  assign wr_test   = reg_req_i && reg_we_i && addr_ok && (reg_addr_i == AddrW'(OffsTest));
  assign wr_cnt    = reg_req_i && reg_we_i && addr_ok && (reg_addr_i == AddrW'(OffsOvfCnt));

  assign clr_mask = wr_state ? reg_wdata_i[NumSrc-1:0] : '0;
  assign set_mask = rise | (wr_test ? reg_wdata_i[NumSrc-1:0] : '0);

  always_comb begin
    rd_data = '0;
    if (reg_addr_i == AddrW'(OffsState))       rd_data = TL_DW'(pending_p0);
    else if (reg_addr_i == AddrW'(OffsEnable)) rd_data = TL_DW'(enable_p0);
    else if (reg_addr_i == AddrW'(OffsId))     rd_data = TL_DW'(irq_id_o);
    else if (reg_addr_i == AddrW'(OffsOvfCnt)) rd_data = TL_DW'(ovf_cnt_p0);
  end

  // Stage p0: edge history, pending, enable and overflow counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_p0    <= '0;
      pending_p0 <= '0;
      enable_p0  <= '0;
      ovf_cnt_p0 <= '0;
    end else begin
      prev_p0    <= src;
      pending_p0 <= (pending_p0 & ~clr_mask) | set_mask;
      if (wr_enable) enable_p0 <= reg_wdata_i[NumSrc-1:0];
      if (wr_cnt) begin
        ovf_cnt_p0 <= ovf_rise ? CntW'(1) : '0;
      end else if (ovf_rise && (ovf_cnt_p0 != {CntW{1'b1}})) begin
        ovf_cnt_p0 <= ovf_cnt_p0 + CntW'(1);
      end
    end
  end

  assign active = pending_p0 & enable_p0;

  irq_prio_enc #(
    .Width (NumSrc),
    .IdW   (4)
  ) u_prio_enc (
    .req_i   (active),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  // Stage p1: registered interrupt outputs and register response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o        <= 1'b0;
      irq_id_o     <= IrqIdNone;
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
      reg_err_o    <= 1'b0;
    end else begin
      irq_o        <= enc_valid;
      irq_id_o     <= enc_valid ? enc_idx : IrqIdNone;
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o  <= (reg_req_i && !reg_we_i && addr_ok) ? rd_data : '0;
      reg_err_o    <= reg_req_i && !addr_ok;
    end
  end

endmodule

// File: doc/uart_irq_aggregator.md
Name: uart_irq_aggregator

Overview:
- Downstream consumer of the UART sideband output struct (uart_sideband_o_t) in the CoralNPU SoC.
- Edge-captures the nine UART interrupt lines into sticky pending bits and masks them with a software enable register.
- Drives a single registered interrupt to the core, plus the lowest-index active source ID.
- Exposes a small single-cycle register port with a saturating rx_overflow event counter for firmware diagnostics.

Parameters:
- NumSrc, 9, number of interrupt sources; fixed by the struct, not overridable.
- CntW, 16, width of the saturating overflow-event counter.
- AddrW, 5, register byte-address width.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- uart_sb_i  in  $bits(uart_sideband_o_t)=12  UART sideband outputs; only intr_* fields are used
- reg_req_i  in  1  register access strobe, one cycle per access
- reg_we_i  in  1  1 = write, 0 = read
- reg_addr_i  in  AddrW  byte address, word aligned
- reg_wdata_i  in  TL_DW=32  write data
- reg_rvalid_o  out  1  response valid, exactly one cycle after reg_req_i
- reg_rdata_o  out  32  read data; 0 for writes and errors
- reg_err_o  out  1  unmapped or misaligned address; qualified by reg_rvalid_o
- irq_o  out  1  aggregated interrupt, level, registered
- irq_id_o  out  4  lowest-index enabled pending source; 4'hF when none

Behaviour:
- Source index map:
  - 0 tx_watermark, 1 tx_empty, 2 rx_watermark, 3 tx_done
  - 4 rx_overflow, 5 rx_frame_err, 6 rx_break_err, 7 rx_timeout, 8 rx_parity_err
- Reset values:
  - All outputs 0, except irq_id_o = 4'hF.
  - pending, enable, counter and edge-detect history all 0.
- Edge capture:
  - rise[i] = src[i] & ~prev[i]; prev updates every cycle.
  - Because history resets to 0, a source held high at reset release sets pending on the first cycle after reset.
- Pending update priority per bit, in order:
  - hardware rise, or TEST write bit = 1 → set
  - else STATE write bit = 1 → clear (W1C)
  - else hold
  - Rise in the same cycle as W1C of that bit: set wins.
- Latency:
  - Rise sampled in cycle N → pending visible N+1 → irq_o / irq_id_o visible N+2.
  - W1C issued in cycle N → irq_o deasserts at N+2 if no other enabled bit is pending.
- irq_o <= |(pending & enable). irq_id_o <= priority encode of (pending & enable), lowest index wins. Both registered.
- Register map, 32-bit words; unused bits read 0 and ignore writes:
  - 0x00 STATE [8:0]: read pending; write 1 to clear.
  - 0x04 ENABLE [8:0]: RW.
  - 0x08 TEST [8:0]: write-only, write 1 to set pending; reads 0.
  - 0x0C ID [3:0]: RO, current irq_id_o.
  - 0x10 OVF_CNT [CntW-1:0]: counts rx_overflow rises, saturates at 0xFFFF; any write clears it.
- Counter corner cases:
  - A write clear and a rise in the same cycle leaves the count at 1.
  - At saturation the count holds, with no wrap.
- Register accesses:
  - Address > 0x10 or addr[1:0] != 0 → reg_err_o = 1 with rvalid; no state change.
  - Back-to-back accesses are allowed every cycle; no backpressure.
- Masking: disabling a bit does not clear its pending bit. Re-enabling re-asserts irq_o two cycles later.
- Reset mid-operation: pending, enable, counter and outputs clear on the next edge. A response in flight is dropped, so reg_rvalid_o = 0.

Decomposition:
- top_pkg additions:
  - uart_irq_idx_e enum, values 0..8
  - UartIrqNum = 9
  - register offset localparams
  - IrqIdNone = 4'hF
- Sub-module irq_prio_enc: a parameterised lowest-index priority encoder with a valid output. It is reusable for other peripherals' aggregators.

Test Plan:
- Reset, then ENABLE=0x1FF, pulse rx_break_err (idx 6) for 1 cycle at cycle N → STATE reads 0x040; irq_o=1 and irq_id_o=6 at N+2.
- Raise tx_empty (idx 1) and rx_parity_err (idx 8) together with ENABLE=0x1FF → irq_id_o=1. Write STATE=0x002 → irq_id_o=8, irq_o stays 1. Write 0x100 → irq_o=0, irq_id_o=0xF.
- Issue W1C STATE=0x010 in the same cycle as an rx_overflow rise → pending[4] stays 1 and OVF_CNT increments by 1.
- Pulse rx_overflow 0x10005 times → OVF_CNT reads 0xFFFF. Write OVF_CNT → reads 0.
- ENABLE=0, TEST write 0x080 → STATE=0x080, irq_o=0. ENABLE=0x080 → irq_o=1 two cycles later, ID read returns 7.
- Read 0x14 and 0x02 → reg_err_o=1, rdata=0, no state change. Hold tx_watermark high through reset release → pending[0]=1 one cycle after rst_i falls.
